// File: rtl/vdp_port_ctrl.sv
// CPU-side VDP port controller: data/control port decode, VRAM access
// sequencing, R0-R7 register file, sticky status flags and frame interrupt.
module vdp_port_ctrl #(
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_port,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              busy,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_wr,
    output logic              vram_rd,
    output logic [7:0]        vram_dout,
    input  logic [7:0]        vram_din,
    input  logic              sprite_collision,
    input  logic              too_many_sprites,
    input  logic              frame_flag,
    input  logic [4:0]        sprite5,
    output logic [1:0]        mode,
    output logic              video_on,
    output logic              vert_retrace_int,
    output logic              sprite_large,
    output logic              sprite_enlarged,
    output logic [13:0]       name_table_addr,
    output logic [13:0]       color_table_addr,
    output logic [13:0]       font_addr,
    output logic [13:0]       sprite_attr_addr,
    output logic [13:0]       sprite_pattern_table_addr,
    output logic [3:0]        text_color,
    output logic [3:0]        back_color,
    output logic              n_int
);

    typedef enum logic {
        LATCH_FIRST,
        LATCH_SECOND
    } latch_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_WRITE,
        SEQ_READ,
        SEQ_CAPTURE
    } seq_t;

    latch_t              r_latch_st, w_latch_next;
    seq_t                r_seq, w_seq_next;

    logic [7:0]          r_regs [NUM_REGS];
    logic [7:0]          r_latch;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_buf;
    logic [7:0]          r_wdata;
    logic [7:0]          r_dout;
    logic                r_f;
    logic                r_c;
    logic                r_5s;
    logic [4:0]          r_spr5;

    logic                w_acc;
    logic                w_data_wr;
    logic                w_data_rd;
    logic                w_ctrl_wr;
    logic                w_stat_rd;
    logic                w_second_wr;
    logic                w_reg_wr;
    logic                w_addr_set;
    logic                w_rd_setup;
    logic [1:0]          w_mode;
    logic                w_mode2;
    logic [13:0]         w_set_addr;
    logic                w_unused;

    assign w_acc       = cpu_req & ~busy & (cpu_wr ^ cpu_rd);
    assign w_data_wr   = w_acc & ~cpu_port & cpu_wr;
    assign w_data_rd   = w_acc & ~cpu_port & cpu_rd;
    assign w_ctrl_wr   = w_acc &  cpu_port & cpu_wr;
    assign w_stat_rd   = w_acc &  cpu_port & cpu_rd;
    assign w_second_wr = w_ctrl_wr & (r_latch_st == LATCH_SECOND);
    assign w_reg_wr    = w_second_wr &  cpu_din[7];
    assign w_addr_set  = w_second_wr & ~cpu_din[7];
    assign w_rd_setup  = w_addr_set  & ~cpu_din[6];
    assign w_set_addr  = {cpu_din[5:0], r_latch};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seq      <= SEQ_IDLE;
            r_latch_st <= LATCH_FIRST;
        end else begin
            r_seq      <= w_seq_next;
            r_latch_st <= w_latch_next;
        end
    end

    always_comb begin
        w_seq_next   = r_seq;
        w_latch_next = r_latch_st;
        case (r_seq)
            SEQ_IDLE: begin
                if (w_data_wr)
                    w_seq_next = SEQ_WRITE;
                else if (w_data_rd || w_rd_setup)
                    w_seq_next = SEQ_READ;
            end
            SEQ_WRITE:   w_seq_next = SEQ_IDLE;
            SEQ_READ:    w_seq_next = SEQ_CAPTURE;
            SEQ_CAPTURE: w_seq_next = SEQ_IDLE;
            default:     w_seq_next = SEQ_IDLE;
        endcase
        if (w_ctrl_wr)
            w_latch_next = (r_latch_st == LATCH_FIRST) ? LATCH_SECOND : LATCH_FIRST;
        else if (w_data_wr || w_data_rd || w_stat_rd)
            w_latch_next = LATCH_FIRST;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
            r_latch <= '0;
            r_addr  <= '0;
            r_buf   <= '0;
            r_wdata <= '0;
            r_dout  <= '0;
            r_f     <= 1'b0;
            r_c     <= 1'b0;
            r_5s    <= 1'b0;
            r_spr5  <= '0;
        end else begin
            if (w_ctrl_wr && (r_latch_st == LATCH_FIRST))
                r_latch <= cpu_din;
            if (w_reg_wr && (32'(cpu_din[2:0]) < NUM_REGS))
                r_regs[cpu_din[2:0]] <= r_latch;

            if (w_addr_set)
                r_addr <= ADDR_W'(w_set_addr);
            else if (r_seq == SEQ_WRITE || r_seq == SEQ_CAPTURE)
                r_addr <= r_addr + ADDR_W'(1);

            if (w_data_wr) begin
                r_buf   <= cpu_din;
                r_wdata <= cpu_din;
            end else if (r_seq == SEQ_CAPTURE) begin
                r_buf   <= vram_din;
            end

            if (w_data_rd)
                r_dout <= r_buf;
            else if (w_stat_rd)
                r_dout <= {r_f, r_5s, r_c, r_spr5};

            // A flag raised in the same cycle as a status-read clear survives.
            r_f  <= frame_flag       | (r_f  & ~w_stat_rd);
            r_c  <= sprite_collision | (r_c  & ~w_stat_rd);
            r_5s <= too_many_sprites | (r_5s & ~w_stat_rd);
            if (too_many_sprites && !r_5s)
                r_spr5 <= sprite5;
            else if (w_stat_rd)
                r_spr5 <= 5'h1f;
        end
    end

    always_comb begin
        w_mode = 2'd1;
        if (r_regs[1][4])
            w_mode = 2'd0;
        else if (r_regs[0][1])
            w_mode = 2'd2;
        else if (r_regs[1][3])
            w_mode = 2'd3;
    end
    assign w_mode2 = (w_mode == 2'd2);

    assign cpu_dout  = r_dout;
    assign busy      = (r_seq != SEQ_IDLE);
    assign vram_addr = r_addr;
    assign vram_wr   = (r_seq == SEQ_WRITE);
    assign vram_rd   = (r_seq == SEQ_READ);
    assign vram_dout = r_wdata;

    assign mode             = w_mode;
    assign video_on         = r_regs[1][6];
    assign vert_retrace_int = r_regs[1][5];
    assign sprite_large     = r_regs[1][1];
    assign sprite_enlarged  = r_regs[1][0];
    assign name_table_addr  = {r_regs[2][3:0], 10'b0};
    assign color_table_addr = w_mode2 ? {r_regs[3][7], 13'b0} : {r_regs[3], 6'b0};
    assign font_addr        = w_mode2 ? {r_regs[4][2], 13'b0} : {r_regs[4][2:0], 11'b0};
    assign sprite_attr_addr = {r_regs[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {r_regs[6][2:0], 11'b0};
    assign text_color       = r_regs[7][7:4];
    assign back_color       = r_regs[7][3:0];
    assign n_int            = ~(r_f & r_regs[1][5]);

    // Register bits the video block does not consume.
    assign w_unused = ^{r_regs[0][7:2], r_regs[0][0], r_regs[1][7], r_regs[1][2],
                        r_regs[2][7:4], r_regs[4][7:3], r_regs[5][7], r_regs[6][7:3]};

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// Randomized self-checking bench for vdp_port_ctrl against a transaction-level
// model of the VDP port (register file, address pointer, buffer, status flags).
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_port = 1'b0, cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        busy;
    logic [13:0] vram_addr;
    logic        vram_wr, vram_rd;
    logic [7:0]  vram_dout;
    logic [7:0]  vram_din = '0;
    logic        sprite_collision = 1'b0, too_many_sprites = 1'b0, frame_flag = 1'b0;
    logic [4:0]  sprite5 = '0;
    logic [1:0]  mode;
    logic        video_on, vert_retrace_int, sprite_large, sprite_enlarged;
    logic [13:0] name_table_addr, color_table_addr, font_addr;
    logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
    logic [3:0]  text_color, back_color;
    logic        n_int;

    always #5 clk = ~clk;

    vdp_port_ctrl #(.ADDR_W(14), .NUM_REGS(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_port(cpu_port), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .busy(busy),
        .vram_addr(vram_addr), .vram_wr(vram_wr), .vram_rd(vram_rd),
        .vram_dout(vram_dout), .vram_din(vram_din),
        .sprite_collision(sprite_collision), .too_many_sprites(too_many_sprites),
        .frame_flag(frame_flag), .sprite5(sprite5),
        .mode(mode), .video_on(video_on), .vert_retrace_int(vert_retrace_int),
        .sprite_large(sprite_large), .sprite_enlarged(sprite_enlarged),
        .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
        .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
        .sprite_pattern_table_addr(sprite_pattern_table_addr),
        .text_color(text_color), .back_color(back_color), .n_int(n_int)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  vram  [16384];
    logic [7:0]  mvram [16384];
    logic [13:0] exp_rd_q [$];
    logic [21:0] exp_wr_q [$];

    int m_regs [8];
    int m_addr, m_latch, m_buf, m_spr5;
    bit m_second, m_f, m_c, m_5s;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // VRAM behind the DUT: read data valid the cycle after vram_rd.
    always @(posedge clk) begin
        if (vram_rd) vram_din <= vram[vram_addr];
        if (vram_wr) vram[vram_addr] <= vram_dout;
    end

    always @(negedge clk) begin
        logic [21:0] ew;
        if (vram_wr) begin
            if (exp_wr_q.size() == 0) chk("wr_unexpected", 32'(vram_wr), 0);
            else begin
                ew = exp_wr_q.pop_front();
                chk("wr_addr", 32'(vram_addr), 32'(ew[21:8]));
                chk("wr_data", 32'(vram_dout), 32'(ew[7:0]));
            end
        end
        if (vram_rd) begin
            if (exp_rd_q.size() == 0) chk("rd_unexpected", 32'(vram_rd), 0);
            else chk("rd_addr", 32'(vram_addr), 32'(exp_rd_q.pop_front()));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_addr = 0; m_latch = 0; m_buf = 0; m_spr5 = 0;
        m_second = 0; m_f = 0; m_c = 0; m_5s = 0;
    endtask

    task automatic model_read();
        exp_rd_q.push_back(14'(m_addr));
        m_buf  = int'(mvram[m_addr]);
        m_addr = (m_addr + 1) % 16384;
    endtask

    task automatic check_outputs();
        int mo;
        if ((m_regs[1] & 'h10) != 0)     mo = 0;
        else if ((m_regs[0] & 2) != 0)  mo = 2;
        else if ((m_regs[1] & 8) != 0)  mo = 3;
        else                            mo = 1;
        chk("mode", 32'(mode), mo);
        chk("video_on", 32'(video_on), (m_regs[1] >> 6) & 1);
        chk("vri", 32'(vert_retrace_int), (m_regs[1] >> 5) & 1);
        chk("spr_large", 32'(sprite_large), (m_regs[1] >> 1) & 1);
        chk("spr_enl", 32'(sprite_enlarged), m_regs[1] & 1);
        chk("name_tbl", 32'(name_table_addr), (m_regs[2] & 15) * 1024);
        chk("color_tbl", 32'(color_table_addr),
            (mo == 2) ? ((m_regs[3] >> 7) & 1) * 8192 : m_regs[3] * 64);
        chk("font", 32'(font_addr),
            (mo == 2) ? ((m_regs[4] >> 2) & 1) * 8192 : (m_regs[4] & 7) * 2048);
        chk("spr_attr", 32'(sprite_attr_addr), (m_regs[5] & 127) * 128);
        chk("spr_pat", 32'(sprite_pattern_table_addr), (m_regs[6] & 7) * 2048);
        chk("text_color", 32'(text_color), m_regs[7] / 16);
        chk("back_color", 32'(back_color), m_regs[7] % 16);
        chk("n_int", 32'(n_int), (m_f && (m_regs[1] & 'h20) != 0) ? 0 : 1);
        chk("vram_addr", 32'(vram_addr), m_addr);
    endtask

    task automatic drive(input logic port, input logic wr, input logic rd, input logic [7:0] din,
                         input logic req, input logic ff, input logic coll, input logic tms,
                         input logic [4:0] s5, input int exp_busy);
        int n;
        @(negedge clk);
        cpu_req = req; cpu_port = port; cpu_wr = wr; cpu_rd = rd; cpu_din = din;
        frame_flag = ff; sprite_collision = coll; too_many_sprites = tms; sprite5 = s5;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0;
        frame_flag = 1'b0; sprite_collision = 1'b0; too_many_sprites = 1'b0;
        n = 0;
        while (busy && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_cycles", n, exp_busy);
        chk("wr_missing", exp_wr_q.size(), 0);
        chk("rd_missing", exp_rd_q.size(), 0);
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        int eb = 0;
        if (!m_second) begin
            m_latch = int'(d); m_second = 1;
        end else begin
            m_second = 0;
            if (d[7]) m_regs[d[2:0]] = m_latch;
            else begin
                m_addr = int'(d & 8'h3f) * 256 + m_latch;
                if (!d[6]) begin model_read(); eb = 2; end
            end
        end
        drive(1'b1, 1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, eb);
        check_outputs();
    endtask

    task automatic data_wr(input logic [7:0] d);
        m_second = 0;
        exp_wr_q.push_back({14'(m_addr), d});
        mvram[m_addr] = d;
        m_buf  = int'(d);
        m_addr = (m_addr + 1) % 16384;
        drive(1'b0, 1'b1, 1'b0, d, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1);
        check_outputs();
    endtask

    task automatic data_rd();
        int e;
        m_second = 0;
        e = m_buf;
        model_read();
        drive(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 2);
        chk("data_rd", 32'(cpu_dout), e);
        check_outputs();
    endtask

    task automatic stat_rd(input logic ff, input logic coll, input logic tms, input logic [4:0] s5);
        int e;
        e = int'(m_f) * 128 + int'(m_5s) * 64 + int'(m_c) * 32 + m_spr5;
        m_second = 0;
        m_f = ff; m_c = coll;
        if (tms && !m_5s) m_spr5 = int'(s5);
        else              m_spr5 = 31;
        m_5s = tms;
        drive(1'b1, 1'b0, 1'b1, 8'($urandom), 1'b1, ff, coll, tms, s5, 0);
        chk("status", 32'(cpu_dout), e);
        check_outputs();
    endtask

    task automatic flags(input logic ff, input logic coll, input logic tms, input logic [4:0] s5);
        m_f = m_f | ff; m_c = m_c | coll;
        if (tms && !m_5s) m_spr5 = int'(s5);
        m_5s = m_5s | tms;
        drive(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, ff, coll, tms, s5, 0);
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            vram[i]  = 8'($urandom);
            mvram[i] = vram[i];
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(cpu_dout), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_vram_wr", 32'(vram_wr), 0);
        chk("rst_vram_rd", 32'(vram_rd), 0);
        check_outputs();
        reset = 1'b1;

        // Register write R7 = 0x40.
        ctrl_wr(8'h40); ctrl_wr(8'h87);
        chk("text_color_4", 32'(text_color), 4);
        chk("back_color_0", 32'(back_color), 0);

        // Write setup at 0, two data writes.
        ctrl_wr(8'h00); ctrl_wr(8'h40);
        data_wr(8'hAA); data_wr(8'h55);
        chk("addr_after_2wr", 32'(vram_addr), 2);

        // Read setup at 3FFF wraps the pointer to 0.
        vram[16383] = 8'h12; mvram[16383] = 8'h12;
        vram[0] = 8'h34;     mvram[0] = 8'h34;
        ctrl_wr(8'hFF); ctrl_wr(8'h3F);
        chk("wrap_addr", 32'(vram_addr), 0);
        data_rd();
        chk("wrap_rd", 32'(cpu_dout), 8'h12);
        data_rd();
        chk("prefetch_rd", 32'(cpu_dout), 8'h34);

        // Frame interrupt.
        ctrl_wr(8'h20); ctrl_wr(8'h81);
        flags(1'b1, 1'b0, 1'b0, 5'd0);
        chk("n_int_low", 32'(n_int), 0);
        stat_rd(1'b0, 1'b0, 1'b0, 5'd0);
        chk("status_f", 32'(cpu_dout[7]), 1);
        chk("n_int_clr", 32'(n_int), 1);
        flags(1'b1, 1'b0, 1'b0, 5'd0);
        stat_rd(1'b1, 1'b0, 1'b0, 5'd0);
        chk("f_set_wins", 32'(n_int), 0);

        // Status read resets the latch.
        ctrl_wr(8'h05);
        stat_rd(1'b0, 1'b0, 1'b0, 5'd0);
        ctrl_wr(8'h00); ctrl_wr(8'h81);
        chk("r1_cleared", 32'(vert_retrace_int), 0);

        // Sprite status.
        flags(1'b0, 1'b1, 1'b1, 5'd9);
        flags(1'b0, 1'b0, 1'b1, 5'd3);
        stat_rd(1'b0, 1'b0, 1'b0, 5'd0);
        chk("status_5s", 32'(cpu_dout), 8'h69);

        // Access while busy is ignored.
        exp_wr_q.push_back({14'(m_addr), 8'hC3});
        mvram[m_addr] = 8'hC3;
        m_buf = 'hC3; m_addr = (m_addr + 1) % 16384; m_second = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_port = 1'b0; cpu_wr = 1'b1; cpu_din = 8'hC3;
        @(posedge clk); #1;
        chk("busy_after_wr", 32'(busy), 1);
        cpu_din = 8'h77;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_wr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_ignore_wr", exp_wr_q.size(), 0);
        check_outputs();

        // Both/neither qualifiers are ignored.
        drive(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
        drive(1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
        drive(1'b1, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
        check_outputs();

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ctrl_wr(8'($urandom));
                3, 4:    data_wr(8'($urandom));
                5, 6:    data_rd();
                7:       stat_rd(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
                8:       flags(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
                default: drive(1'($urandom), 1'b1, 1'b1, 8'($urandom), 1'b1,
                               1'b0, 1'b0, 1'b0, 5'd0, 0);
            endcase
        end

        // Reset in the middle of a READ sequence.
        ctrl_wr(8'h12); ctrl_wr(8'h83);
        data_wr(8'h9C);
        m_second = 0;
        model_read();
        @(negedge clk);
        cpu_req = 1'b1; cpu_port = 1'b0; cpu_rd = 1'b1;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_rd = 1'b0;
        chk("busy_in_read", 32'(busy), 1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_busy", 32'(busy), 0);
        chk("arst_vram_rd", 32'(vram_rd), 0);
        chk("arst_vram_wr", 32'(vram_wr), 0);
        chk("arst_dout", 32'(cpu_dout), 0);
        check_outputs();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rd_missing_rst", exp_rd_q.size(), 0);
        check_outputs();
        ctrl_wr(8'h00); ctrl_wr(8'h00);
        data_rd();
        data_rd();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
